// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot and periodic (auto-reload) modes.
// Raises a single-cycle 'expired' pulse at terminal count and flags clamped load values.
module countdown_timer #(
    parameter int STEP        = 1,
    parameter int UPPER_BOUND = 65536,
    parameter int SIZE        = $clog2(UPPER_BOUND)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          en,
    input  logic          load,
    input  logic [SIZE:0] load_val,
    input  logic          periodic,
    input  logic          abort,
    output logic [SIZE:0] cnt,
    output logic          busy,
    output logic          expired,
    output logic          load_err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_t;

    localparam logic [SIZE:0] STEP_W  = (SIZE+1)'(STEP);
    localparam logic [SIZE:0] BOUND_W = (SIZE+1)'(UPPER_BOUND);
    localparam logic [SIZE:0] MAX_W   = (SIZE+1)'(UPPER_BOUND - 1);

    state_t        state_q, state_d;
    logic [SIZE:0] cnt_q, cnt_d;
    logic [SIZE:0] reload_q, reload_d;
    logic          mode_q, mode_d;
    logic          busy_q, busy_d;
    logic          expired_q, expired_d;
    logic          load_err_q, load_err_d;
    logic          wrap;
    logic          over_range;
    logic [SIZE:0] load_clamped;

    // State register: every output is a flop so all outputs change only on the clock edge
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            reload_q   <= '0;
            mode_q     <= 1'b0;
            busy_q     <= 1'b0;
            expired_q  <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            reload_q   <= reload_d;
            mode_q     <= mode_d;
            busy_q     <= busy_d;
            expired_q  <= expired_d;
            load_err_q <= load_err_d;
        end
    end

    // Next-state and datapath: abort beats load, load beats the per-state decrement
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        reload_d     = reload_q;
        mode_d       = mode_q;
        load_err_d   = 1'b0;
        wrap         = 1'b0;
        over_range   = (load_val >= BOUND_W);
        load_clamped = over_range ? MAX_W : load_val;

        if (abort) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (load) begin
            cnt_d      = load_clamped;
            reload_d   = load_clamped;
            load_err_d = over_range;
            if (load_clamped == '0) begin
                state_d = EXPIRED;
                mode_d  = 1'b0;
            end else begin
                state_d = RUN;
                mode_d  = periodic;
            end
        end else begin
            case (state_q)
                RUN: begin
                    if (en) begin
                        if (cnt_q > STEP_W) begin
                            cnt_d = cnt_q - STEP_W;
                        end else if (mode_q) begin
                            cnt_d = reload_q;
                            wrap  = 1'b1;
                        end else begin
                            cnt_d   = '0;
                            state_d = EXPIRED;
                        end
                    end
                end
                EXPIRED: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // Output decode from the next state so busy/expired land in the same cycle as cnt
    always_comb begin
        busy_d    = (state_d == RUN);
        expired_d = (state_d == EXPIRED) || wrap;
    end

    assign cnt      = cnt_q;
    assign busy     = busy_q;
    assign expired  = expired_q;
    assign load_err = load_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: scoreboard bench for countdown_timer with STEP=1 and STEP=3 instances.
module tb_countdown_timer;

    typedef struct packed {
        logic        reset;
        logic        en;
        logic        load;
        logic [16:0] load_val;
        logic        periodic;
        logic        abort;
    } stim_t;

    typedef struct packed {
        logic [16:0] cnt;
        logic        busy;
        logic        expired;
        logic        load_err;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        en;
    logic        load;
    logic [16:0] load_val;
    logic        periodic;
    logic        abort;
    logic [16:0] cnt, cnt3;
    logic        busy, busy3;
    logic        expired, expired3;
    logic        load_err, load_err3;

    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;

    countdown_timer #(.STEP(1), .UPPER_BOUND(65536)) dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .periodic(periodic), .abort(abort),
        .cnt(cnt), .busy(busy), .expired(expired), .load_err(load_err)
    );

    countdown_timer #(.STEP(3), .UPPER_BOUND(65536)) dut3 (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_val(load_val),
        .periodic(periodic), .abort(abort),
        .cnt(cnt3), .busy(busy3), .expired(expired3), .load_err(load_err3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of stimulus onto the shared inputs
    task automatic drive(input stim_t s);
        reset    = s.reset;
        en       = s.en;
        load     = s.load;
        load_val = s.load_val;
        periodic = s.periodic;
        abort    = s.abort;
    endtask

    task automatic test_reset();
        exp_t e, o, o3;
        for (int i = 0; i < 2; i++) sb.push_back('{17'd0, 1'b0, 1'b0, 1'b0});
        for (int i = 0; i < 2; i++) begin
            drive('{1'b1, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0});
            @(posedge clk); #1;
            e  = sb.pop_front();
            o  = {cnt, busy, expired, load_err};
            o3 = {cnt3, busy3, expired3, load_err3};
            checks++;
            if (o !== e) $display("[TB] FAIL reset[%0d]: got %h expected %h", i, o, e);
            else passes++;
            checks++;
            if (o3 !== e) $display("[TB] FAIL reset_step3[%0d]: got %h expected %h", i, o3, e);
            else passes++;
        end
    endtask

    task automatic test_one_shot();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 1'b1, 17'd3, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd3, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd3, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd3, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd3, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd3, 1'b0, 1'b0}};
        ex = '{'{17'd3, 1'b1, 1'b0, 1'b0},
               '{17'd2, 1'b1, 1'b0, 1'b0},
               '{17'd1, 1'b1, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b1, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) sb.push_back(ex[i]);
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {cnt, busy, expired, load_err};
            checks++;
            if (o !== e)
                $display("[TB] FAIL one_shot[%0d]: got cnt=%0d busy=%b exp=%b err=%b, expected cnt=%0d busy=%b exp=%b err=%b",
                         i, o.cnt, o.busy, o.expired, o.load_err, e.cnt, e.busy, e.expired, e.load_err);
            else passes++;
        end
    endtask

    task automatic test_periodic();
        stim_t st[14];
        exp_t  ex[14];
        exp_t  e, o;
        for (int k = 0; k < 13; k++) begin
            st[k] = '{1'b0, 1'b1, (k == 0), 17'd4, 1'b1, 1'b0};
            ex[k] = '{17'(4 - (k % 4)), 1'b1, ((k % 4) == 0) && (k > 0), 1'b0};
        end
        st[13] = '{1'b0, 1'b1, 1'b0, 17'd4, 1'b1, 1'b1};
        ex[13] = '{17'd0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 14; i++) sb.push_back(ex[i]);
        for (int i = 0; i < 14; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {cnt, busy, expired, load_err};
            checks++;
            if (o !== e)
                $display("[TB] FAIL periodic[%0d]: got cnt=%0d busy=%b exp=%b err=%b, expected cnt=%0d busy=%b exp=%b err=%b",
                         i, o.cnt, o.busy, o.expired, o.load_err, e.cnt, e.busy, e.expired, e.load_err);
            else passes++;
        end
    endtask

    task automatic test_step3();
        stim_t st[11];
        exp_t  ex[11];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 1'b1, 17'd7, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd7, 1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b0, 17'd7, 1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b0, 17'd7, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd7, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd7, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd7, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b1, 17'd2, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd2, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd2, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd2, 1'b1, 1'b1}};
        ex = '{'{17'd7, 1'b1, 1'b0, 1'b0},
               '{17'd4, 1'b1, 1'b0, 1'b0},
               '{17'd4, 1'b1, 1'b0, 1'b0},
               '{17'd4, 1'b1, 1'b0, 1'b0},
               '{17'd1, 1'b1, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b1, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0},
               '{17'd2, 1'b1, 1'b0, 1'b0},
               '{17'd2, 1'b1, 1'b1, 1'b0},
               '{17'd2, 1'b1, 1'b1, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 11; i++) sb.push_back(ex[i]);
        for (int i = 0; i < 11; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {cnt3, busy3, expired3, load_err3};
            checks++;
            if (o !== e)
                $display("[TB] FAIL step3[%0d]: got cnt=%0d busy=%b exp=%b err=%b, expected cnt=%0d busy=%b exp=%b err=%b",
                         i, o.cnt, o.busy, o.expired, o.load_err, e.cnt, e.busy, e.expired, e.load_err);
            else passes++;
        end
    endtask

    task automatic test_clamp();
        stim_t st[7];
        exp_t  ex[7];
        exp_t  e, o;
        st = '{'{1'b0, 1'b0, 1'b1, 17'd65541, 1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b1, 17'd0,     1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b1, 17'd65536, 1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b1, 17'd65535, 1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b0, 17'd0,     1'b0, 1'b1}};
        ex = '{'{17'd65535, 1'b1, 1'b0, 1'b1},
               '{17'd65535, 1'b1, 1'b0, 1'b0},
               '{17'd0,     1'b0, 1'b1, 1'b0},
               '{17'd0,     1'b0, 1'b0, 1'b0},
               '{17'd65535, 1'b1, 1'b0, 1'b1},
               '{17'd65535, 1'b1, 1'b0, 1'b0},
               '{17'd0,     1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 7; i++) sb.push_back(ex[i]);
        for (int i = 0; i < 7; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {cnt, busy, expired, load_err};
            checks++;
            if (o !== e)
                $display("[TB] FAIL clamp[%0d]: got cnt=%0d busy=%b exp=%b err=%b, expected cnt=%0d busy=%b exp=%b err=%b",
                         i, o.cnt, o.busy, o.expired, o.load_err, e.cnt, e.busy, e.expired, e.load_err);
            else passes++;
        end
    endtask

    task automatic test_abort();
        stim_t st[15];
        exp_t  ex[15];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 1'b1, 17'd9,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b1},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b1, 17'd70000, 1'b0, 1'b1},
               '{1'b0, 1'b1, 1'b1, 17'd5,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b1, 17'd9,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0,     1'b0, 1'b1}};
        ex = '{'{17'd9, 1'b1, 1'b0, 1'b0},
               '{17'd8, 1'b1, 1'b0, 1'b0},
               '{17'd7, 1'b1, 1'b0, 1'b0},
               '{17'd6, 1'b1, 1'b0, 1'b0},
               '{17'd5, 1'b1, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0},
               '{17'd5, 1'b1, 1'b0, 1'b0},
               '{17'd4, 1'b1, 1'b0, 1'b0},
               '{17'd3, 1'b1, 1'b0, 1'b0},
               '{17'd2, 1'b1, 1'b0, 1'b0},
               '{17'd9, 1'b1, 1'b0, 1'b0},
               '{17'd8, 1'b1, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 15; i++) sb.push_back(ex[i]);
        for (int i = 0; i < 15; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {cnt, busy, expired, load_err};
            checks++;
            if (o !== e)
                $display("[TB] FAIL abort[%0d]: got cnt=%0d busy=%b exp=%b err=%b, expected cnt=%0d busy=%b exp=%b err=%b",
                         i, o.cnt, o.busy, o.expired, o.load_err, e.cnt, e.busy, e.expired, e.load_err);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t st[9];
        exp_t  ex[9];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 1'b1, 17'd1, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b1, 17'd2, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b1, 17'd1, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b0, 1'b0, 17'd0, 1'b0, 1'b1}};
        ex = '{'{17'd1, 1'b1, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b1, 1'b0},
               '{17'd2, 1'b1, 1'b0, 1'b0},
               '{17'd1, 1'b1, 1'b0, 1'b0},
               '{17'd1, 1'b1, 1'b0, 1'b0},
               '{17'd1, 1'b1, 1'b1, 1'b0},
               '{17'd1, 1'b1, 1'b1, 1'b0},
               '{17'd1, 1'b1, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 9; i++) sb.push_back(ex[i]);
        for (int i = 0; i < 9; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {cnt, busy, expired, load_err};
            checks++;
            if (o !== e)
                $display("[TB] FAIL back_to_back[%0d]: got cnt=%0d busy=%b exp=%b err=%b, expected cnt=%0d busy=%b exp=%b err=%b",
                         i, o.cnt, o.busy, o.expired, o.load_err, e.cnt, e.busy, e.expired, e.load_err);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        stim_t st[6];
        exp_t  ex[6];
        exp_t  e, o;
        st = '{'{1'b0, 1'b1, 1'b1, 17'd8, 1'b1, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b1, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0},
               '{1'b0, 1'b1, 1'b0, 17'd0, 1'b0, 1'b0}};
        ex = '{'{17'd8, 1'b1, 1'b0, 1'b0},
               '{17'd7, 1'b1, 1'b0, 1'b0},
               '{17'd6, 1'b1, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0},
               '{17'd0, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 6; i++) sb.push_back(ex[i]);
        for (int i = 0; i < 6; i++) begin
            drive(st[i]);
            @(posedge clk); #1;
            e = sb.pop_front();
            o = {cnt, busy, expired, load_err};
            checks++;
            if (o !== e)
                $display("[TB] FAIL reset_mid[%0d]: got cnt=%0d busy=%b exp=%b err=%b, expected cnt=%0d busy=%b exp=%b err=%b",
                         i, o.cnt, o.busy, o.expired, o.load_err, e.cnt, e.busy, e.expired, e.load_err);
            else passes++;
        end
    endtask

    // Run every scenario in sequence and print the summary
    initial begin
        drive('{1'b1, 1'b0, 1'b0, 17'd0, 1'b0, 1'b0});
        test_reset();
        test_one_shot();
        test_periodic();
        test_step3();
        test_clamp();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    // Watchdog so the run always ends even if the sequence stalls
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/countdown_timer.md
# countdown_timer

Loadable down-counter with one-shot and periodic modes, the decrementing counterpart of the free-running up-counter. A value is loaded, decremented by STEP on each enabled cycle, and a single-cycle `expired` pulse is raised when it reaches zero. Used for timeouts, baud/tick dividers and retry delays alongside the up-counter in the same clock domain.

## Interface
- STEP, 1, decrement applied per enabled cycle; must be ≥1.
- UPPER_BOUND, 65536, exclusive upper limit for loaded values.
- SIZE, $clog2(UPPER_BOUND), counter MSB index; `cnt` is SIZE+1 bits wide.

- clk  in  1  rising-edge clock; the only clock.
- reset  in  1  synchronous, active-high reset.
- en  in  1  count enable; gates decrement only.
- load  in  1  load `load_val` and start counting.
- load_val  in  SIZE+1  start/reload value.
- periodic  in  1  mode, sampled only when `load` is accepted: 1 = auto-reload, 0 = one-shot.
- abort  in  1  stop immediately, no expiry.
- cnt  out  SIZE+1  current count (registered).
- busy  out  1  high while in RUN.
- expired  out  1  one-cycle pulse on reaching terminal count.
- load_err  out  1  one-cycle pulse: `load_val` was clamped.

## Operation
- States: IDLE, RUN, EXPIRED.
- Priority per cycle: reset > abort > load > decrement.
- Reset: state IDLE, cnt=0, busy=0, expired=0, load_err=0, reload register=0, mode=one-shot.
- Load (any state): value v = min(load_val, UPPER_BOUND-1). If load_val ≥ UPPER_BOUND, load_err=1 next cycle. Reload register ← v, mode ← periodic. cnt ← v.
  - If v = 0: next state EXPIRED (expired=1, busy=0); periodic ignored, mode forced to one-shot.
  - Else: next state RUN.
  - Load during RUN restarts; no expired pulse for the interrupted count.
- RUN, en=1: if cnt > STEP, cnt ← cnt − STEP. Otherwise terminal:
  - one-shot: cnt ← 0, next EXPIRED.
  - periodic: cnt ← reload register, stay RUN, expired=1 for that one cycle.
- RUN, en=0: hold cnt and state.
- EXPIRED: lasts exactly one cycle, cnt=0, expired=1, busy=0; then IDLE unconditionally unless load/abort.
- IDLE: cnt holds; en ignored.
- Abort (any state): cnt ← 0, IDLE, no expired pulse. Abort with load in the same cycle: abort wins, load dropped, load_err not raised.
- Arithmetic: subtraction never wraps; counts floor at 0 (one-shot) or reload (periodic). A final step smaller than STEP is allowed (cnt=2, STEP=3 → terminal).

## Timing
- All outputs registered; changes follow the clock edge that samples the input.
- load at edge N → cnt=v, busy=1 after N; first decrement at edge N+1 if en=1.
- One-shot v=K, STEP=1, en continuously 1: cnt reads 0 and expired=1 in the K-th cycle after the load edge; busy falls in the same cycle; IDLE the next cycle.
- Periodic period = ceil(v/STEP) enabled cycles between expired pulses.
- expired never high for two consecutive cycles except periodic with ceil(v/STEP)=1 (pulses every enabled cycle).
- Reset mid-count: all outputs at reset values after the reset edge; no expired pulse.

## Test plan
- Reset, load_val=3, periodic=0, en=1 → cnt 3,2,1,0; expired=1 only at cnt=0; busy 1,1,1,0; IDLE next cycle with cnt=0.
- load_val=4, periodic=1, STEP=1, en=1 for 12 cycles → cnt 4,3,2,1,4,3,2,1,4,…; expired high exactly in cycles showing the reload 4 after the first; busy stays 1.
- STEP=3, load_val=7, one-shot → cnt 7,4,1,0; expired with cnt=0; toggling en=0 mid-count holds cnt without advancing.
- load_val=UPPER_BOUND+5 → cnt=UPPER_BOUND-1, load_err pulses once; load_val=0 → immediate EXPIRED cycle, expired=1, busy=0.
- Abort at cnt=5 in RUN → cnt=0, busy=0, no expired; abort+load same cycle → IDLE, cnt=0; reload in RUN at cnt=2 with 9 → restarts at 9, no pulse.
- reset asserted while cnt=6 in periodic RUN → cnt=0, busy=0, expired=0, load_err=0 next cycle; subsequent en=1 with no load leaves cnt at 0.
